// File: rtl/rr_mux_pkg.sv
// rr_mux_pkg: shared helpers for the round-robin stream mux.
// Provides clog2_min1(n), a $clog2 that never returns 0 so index ports stay at least 1 bit wide.
package rr_mux_pkg;
  function automatic int clog2_min1(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational wrap-around priority arbiter.
// Ports: req (per-channel request), ptr (highest-priority channel), en (grant enable),
//        gnt (one-hot grant), idx (encoded index of gnt).
module rr_arbiter
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int SEL_W  = clog2_min1(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [SEL_W-1:0]  ptr,
  input  logic              en,
  output logic [NUM_CH-1:0] gnt,
  output logic [SEL_W-1:0]  idx
);
  always_comb begin
    gnt = '0;
    idx = '0;
    // Scan from farthest to nearest so the channel closest to ptr is written last and wins.
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      int c;
      c = (int'(ptr) + k) % NUM_CH;
      if (en && req[c]) begin
        gnt    = '0;
        gnt[c] = 1'b1;
        idx    = SEL_W'(c);
      end
    end
  end
endmodule

// File: rtl/rr_stream_mux.sv
// rr_stream_mux: N-input valid/ready stream mux with round-robin channel choice and a registered output.
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready per channel (channel i data at
//        [i*DATA_W +: DATA_W]); out_valid/out_data/out_sel/out_ready for the single consumer.
// Macro RR_MUX_LOCK_EN adds in_last/out_last and holds a granted channel until its packet ends.
module rr_stream_mux
  import rr_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = 8,
  parameter int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_CH-1:0]        in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic [NUM_CH-1:0]        in_ready,
`ifdef RR_MUX_LOCK_EN
  input  logic [NUM_CH-1:0]        in_last,
  output logic                     out_last,
`endif
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_sel,
  input  logic                     out_ready
);
  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  win;
  logic [SEL_W-1:0]  nxt;
  logic [NUM_CH-1:0] req;
  logic              load_ok;
  logic              xfer;
`ifdef RR_MUX_LOCK_EN
  logic              locked;
  logic [SEL_W-1:0]  lock_ch;
  assign req = locked ? (in_valid & (NUM_CH'(1) << lock_ch)) : in_valid;
`else
  assign req = in_valid;
`endif
  assign load_ok = !out_valid || out_ready;
  assign xfer    = |in_ready;
  assign nxt     = (win == SEL_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
  // Grants are suppressed during reset since any beat taken then would be discarded.
  rr_arbiter #(.NUM_CH(NUM_CH), .SEL_W(SEL_W)) u_arb (
    .req (req),
    .ptr (ptr),
    .en  (load_ok && !rst),
    .gnt (in_ready),
    .idx (win)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
`ifdef RR_MUX_LOCK_EN
      out_last  <= 1'b0;
      locked    <= 1'b0;
      lock_ch   <= '0;
`endif
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[win*DATA_W +: DATA_W];
      out_sel   <= win;
`ifdef RR_MUX_LOCK_EN
      out_last  <= in_last[win];
      locked    <= !in_last[win];
      lock_ch   <= win;
      if (in_last[win]) ptr <= nxt;
`else
      ptr       <= nxt;
`endif
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rr_stream_mux.sv
// tb_rr_stream_mux: directed checks of rr_stream_mux with 4 and 3 channels.
module tb_rr_stream_mux;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  v4;
  logic [31:0] d4;
  logic [3:0]  r4;
  logic        ov4;
  logic [7:0]  od4;
  logic [1:0]  os4;
  logic        ordy4;
  logic [2:0]  v3;
  logic [23:0] d3;
  logic [2:0]  r3;
  logic        ov3;
  logic [7:0]  od3;
  logic [1:0]  os3;
  int          total = 0;
  int          bad = 0;
`ifdef RR_MUX_LOCK_EN
  logic [3:0]  l4;
  logic        ol4;
  logic [2:0]  l3;
  logic        ol3;
`endif

  always #5 clk = ~clk;

  rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .in_data(d4), .in_ready(r4),
`ifdef RR_MUX_LOCK_EN
    .in_last(l4), .out_last(ol4),
`endif
    .out_valid(ov4), .out_data(od4), .out_sel(os4), .out_ready(ordy4)
  );

  rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) u3 (
    .clk(clk), .rst(rst), .in_valid(v3), .in_data(d3), .in_ready(r3),
`ifdef RR_MUX_LOCK_EN
    .in_last(l3), .out_last(ol3),
`endif
    .out_valid(ov3), .out_data(od3), .out_sel(os3), .out_ready(1'b1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    v4 = 4'b1111;
    d4 = 32'hA3A2A1A0;
    ordy4 = 1'b1;
    v3 = 3'b000;
    d3 = 24'hC2C1C0;
`ifdef RR_MUX_LOCK_EN
    l4 = 4'b1111;
    l3 = 3'b111;
`endif
    tick();
    tick();
    chk("rst_valid", ov4, 0);
    chk("rst_sel", os4, 0);
    chk("rst_ready", r4, 4'b0000);
    chk("rst_data", od4, 0);
    rst = 1'b0;
    #1;
    chk("first_ready", r4, 4'b0001);
    // rotation: all valid, one beat per cycle
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rot_valid", ov4, 1);
      chk("rot_sel", os4, i % 4);
      chk("rot_data", od4, 8'hA0 + (i % 4));
    end
    // sparse: move ptr to 2 via channel 1, then only channels 1 and 3
    v4 = 4'b0010;
    tick();
    chk("sp_sel1", os4, 1);
    v4 = 4'b1010;
    #1;
    chk("sp_ready", r4, 4'b1000);
    tick();
    chk("sp_sel_a", os4, 3);
    tick();
    chk("sp_sel_b", os4, 1);
    tick();
    chk("sp_sel_c", os4, 3);
    // backpressure: hold 0x5C from channel 0
    v4 = 4'b0001;
    d4 = 32'hA3A2A15C;
    tick();
    chk("bp_load", od4, 8'h5C);
    ordy4 = 1'b0;
    v4 = 4'b1111;
    #1;
    chk("bp_ready0", r4, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold", od4, 8'h5C);
      chk("bp_valid", ov4, 1);
      chk("bp_ready", r4, 4'b0000);
    end
    ordy4 = 1'b1;
    #1;
    chk("bp_rel_ready", r4, 4'b0010);
    tick();
    chk("bp_next_data", od4, 8'hA1);
    chk("bp_next_sel", os4, 1);
    v4 = 4'b0000;
    tick();
    chk("drain_valid", ov4, 0);
    chk("drain_data", od4, 8'hA1);
    chk("idle_ready", r4, 4'b0000);
    // wrap on 3 channels
    v3 = 3'b100;
    tick();
    chk("w3_sel2", os3, 2);
    chk("w3_data2", od3, 8'hC2);
    v3 = 3'b111;
    tick();
    chk("w3_sel0", os3, 0);
    tick();
    chk("w3_sel1", os3, 1);
    chk("w3_data1", od3, 8'hC1);
    v3 = 3'b000;
`ifdef RR_MUX_LOCK_EN
    // lock: bring ptr to 1, then channel 1 sends a 3-beat packet while channel 2 waits
    v4 = 4'b0001;
    tick();
    chk("lk_pre", os4, 0);
    v4 = 4'b0110;
    l4 = 4'b0100;
    tick();
    chk("lk_sel_a", os4, 1);
    chk("lk_last_a", ol4, 0);
    chk("lk_ready", r4, 4'b0010);
    tick();
    chk("lk_sel_b", os4, 1);
    chk("lk_last_b", ol4, 0);
    l4 = 4'b0110;
    tick();
    chk("lk_sel_c", os4, 1);
    chk("lk_last_c", ol4, 1);
    tick();
    chk("lk_sel_d", os4, 2);
    v4 = 4'b0000;
`endif
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rr_stream_mux.md
# rr_stream_mux

Parametrised N-input stream multiplexer: the channel is chosen by a round-robin arbiter rather than an external select, and every input and the output carry a valid/ready handshake. The output goes through one register stage, so the block sits between several producer streams and a single shared consumer, such as a shared bus port or a serialiser. With `RR_MUX_LOCK_EN` defined, a granted channel holds the output until its packet ends.

## Interface
- `NUM_CH`, default 4: number of input channels; legal range is 2 or more.
- `DATA_W`, default 8: width of each channel's data.
- `SEL_W`, default `$clog2(NUM_CH)`: width of the channel index.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `in_valid` input NUM_CH: per-channel valid; bit i belongs to channel i.
- `in_data` input NUM_CH*DATA_W: flattened data; channel i occupies `[i*DATA_W +: DATA_W]`.
- `in_ready` output NUM_CH: per-channel accept; at most one bit is high in any cycle.
- `out_valid` output 1: output register holds a beat.
- `out_data` output DATA_W: registered data of that beat.
- `out_sel` output SEL_W: index of the channel the current beat came from.
- `out_ready` input 1: consumer accepts the beat.
- `in_last` input NUM_CH, present only with `RR_MUX_LOCK_EN`: per-channel end-of-packet flag.
- `out_last` output 1, present only with `RR_MUX_LOCK_EN`: registered end-of-packet flag.

## Operation
- State:
  - Output register: `out_valid`, `out_data`, `out_sel`, plus `out_last` when lock mode is compiled in.
  - Round-robin pointer `ptr` (SEL_W bits).
  - In lock mode only: `locked` flag and `lock_ch` (SEL_W bits).
- Load condition `load_ok = !out_valid || out_ready`.
- Grant rule:
  - When `load_ok` is high, the winner is the first channel i with `in_valid[i]` high, searching i = ptr, ptr+1, …, wrapping modulo NUM_CH.
  - `in_ready[winner]` is high for that cycle; all other `in_ready` bits are low.
  - When `load_ok` is low, all `in_ready` bits are low.
- Transfer: a beat moves on a channel when `in_valid[i] && in_ready[i]`.
- On transfer:
  - The output register loads the winner's data and index, and `out_valid` becomes 1.
  - `ptr` becomes winner+1. When winner = NUM_CH-1, `ptr` wraps to 0, including for non-power-of-two NUM_CH.
- Output accepted with no new grant: `out_valid` becomes 0; `out_data` and `out_sel` hold their values.
- No valid inputs: no grant; `ptr` holds.
- `in_ready` depends only on registered state, `out_ready` and `in_valid`; it has no combinational path from `in_data`.
- The winner's `in_ready` does depend combinationally on `in_valid`. Producers must not make `in_valid` depend on `in_ready`.
- Reset values: `out_valid` 0, `out_data` 0, `out_sel` 0, `out_last` 0, `ptr` 0, `locked` 0, `lock_ch` 0.
- Reset overrides everything, including a beat held mid-handshake. A beat in the output register at reset is discarded.

## Timing
- Latency: an input beat transferred in cycle n is visible on the outputs in cycle n+1.
- Throughput: one beat per cycle while `out_ready` stays high and some input is valid.
- Consumer stall: while `out_valid && !out_ready`, the output register and `ptr` are frozen and `in_ready` is all-zero.
- Simultaneous drain and load: when `out_valid && out_ready` and an input is valid in the same cycle, the register reloads with no bubble.
- Fairness: a channel that stays valid is granted within NUM_CH grants.

## Configuration
- Macro: `RR_MUX_LOCK_EN`.
- Defined (packet lock):
  - A grant of a beat with `in_last` = 0 sets `locked` = 1 and `lock_ch` = winner.
  - While locked, only `lock_ch` may win; if `lock_ch` is not valid, no grant is made and other channels wait.
  - A transfer with `in_last` = 1 clears `locked`.
  - `ptr` advances only on that last-beat transfer.
  - `out_last` is registered alongside `out_data`.
- Undefined: every beat is arbitrated independently, and the `in_last`/`out_last` ports and the lock state do not exist.

## Structure
- Package `rr_mux_pkg`: function `clog2_min1(n)`, which returns `$clog2(n)` but at least 1.
- Sub-module `rr_arbiter` (parameter NUM_CH): inputs `req`, `ptr`, `en`; outputs a one-hot `gnt` and its encoded index, with wrap-around priority. This module is purely combinational; `ptr` stays in `rr_stream_mux`.
- Top level holds the output register, pointer and lock logic.

## Test plan
- Reset check: apply `rst` for 2 cycles with all inputs valid → `out_valid` = 0, `out_sel` = 0, `in_ready` = 0000 during reset; first grant after reset goes to channel 0.
- Rotation: NUM_CH=4, all valid, `out_ready` = 1, data on channel i = 0xA0+i → `out_sel` sequence 0,1,2,3,0 and `out_data` A0,A1,A2,A3,A0, one beat per cycle.
- Sparse requests: only channels 1 and 3 valid, `ptr` = 2 → grant 3, then 1, then 3.
- Backpressure: `out_ready` = 0 for 3 cycles while holding beat 0x5C → `out_data` stays 0x5C, `in_ready` = 0000, `ptr` unchanged; `out_ready` = 1 → next beat appears the next cycle with no beat lost or duplicated.
- Wrap with NUM_CH=3: only channel 2 valid, then all valid → grant 2, then 0, then 1.
- Lock mode (`RR_MUX_LOCK_EN`): channel 1 sends 3 beats with `in_last` = 0,0,1 while channel 2 is valid → `out_sel` reads 1,1,1 and then 2; `out_last` = 1 only on the third beat.
